// File: rtl/time_set_pkg.sv
// Shared types and helpers for the manual time-setting controller:
// state codes, BCD range limits and the wrapping BCD increment.
package time_set_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  localparam logic [7:0] HOUR24_MAX = 8'h23;
  localparam logic [7:0] HOUR12_MAX = 8'h11;
  localparam logic [7:0] MIN_MAX    = 8'h59;

  // BCD ordering matches numeric ordering for valid digits, so a plain
  // compare catches both "at the limit" and out-of-range shadows.
  function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] value,
                                               input logic [7:0] max);
    logic [7:0] r;
    if (value >= max) begin
      r = 8'h00;
    end else if (value[3:0] >= 4'd9) begin
      r = {value[7:4] + 4'd1, 4'd0};
    end else begin
      r = {value[7:4], value[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Tact-switch conditioner: 2-flop synchroniser, stability counter,
// debounced level (released = 1) and a one-cycle press pulse on 1->0.
module sw_debounce #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter tracks consecutive samples that disagree with the level;
  // any agreeing sample (a bounce back) restarts it.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Manual hour/minute setting controller: RUN -> SET_HOUR -> SET_MIN -> COMMIT.
// Optional AUTO_REPEAT_EN: holding INC across ticks generates repeat increments.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEB_CYCLES    = 20000,
  parameter int TIMEOUT_TICKS = 30,
  parameter int TO_W          = 6
) (
  input  logic       pCLK,
  input  logic       nRST,
  input  logic       sw_mode_n,
  input  logic       sw_inc_n,
  input  logic       tick_1hz,
  input  logic       h24,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  output logic       hold,
  output logic       load_en,
  output logic [7:0] load_hour,
  output logic [7:0] load_min,
  output logic       sec_clr,
  output logic [3:0] blank_mask,
  output logic [1:0] state_o
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_TICKS);

  logic mode_press, inc_press, mode_level, inc_level;
  logic inc_event;
  logic unused_lvl;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk_i   (pCLK),
    .rst_ni  (nRST),
    .sw_n_i  (sw_mode_n),
    .level_o (mode_level),
    .press_o (mode_press)
  );

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk_i   (pCLK),
    .rst_ni  (nRST),
    .sw_n_i  (sw_inc_n),
    .level_o (inc_level),
    .press_o (inc_press)
  );

  assign unused_lvl = mode_level ^ inc_level;

  state_t          state_q, state_d;
  logic [7:0]      hour_q, hour_d, min_q, min_d;
  logic [TO_W-1:0] to_q, to_d, to_inc;
  logic            phase_q, phase_d;
  logic            hold_q, load_en_q, sec_clr_q;
  logic [3:0]      blank_q, blank_d;

`ifdef AUTO_REPEAT_EN
  logic [1:0] rep_cnt_q, rep_cnt_d;
  logic       rep_event;
  logic       in_set;

  assign in_set = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);

  // Two ticks of continuous hold arm the repeater; every later tick fires.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_event = 1'b0;
    if (!in_set || inc_level) begin
      rep_cnt_d = 2'd0;
    end else if (tick_1hz) begin
      if (rep_cnt_q == 2'd2) begin
        rep_event = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge pCLK) begin
    if (!nRST) begin
      rep_cnt_q <= 2'd0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign inc_event = inc_press | rep_event;
`else
  assign inc_event = inc_press;
`endif

  assign to_inc = to_q + TO_W'(1);

  // Mode has priority over inc; a press in a SET state also clears the timeout.
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    to_d    = to_q;
    phase_d = phase_q;
    case (state_q)
      ST_RUN: begin
        to_d    = '0;
        phase_d = 1'b0;
        if (mode_press) begin
          hour_d  = cur_hour;
          min_d   = cur_min;
          state_d = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR, ST_SET_MIN: begin
        if (tick_1hz) begin
          phase_d = ~phase_q;
        end
        if (mode_press) begin
          to_d    = '0;
          state_d = (state_q == ST_SET_HOUR) ? ST_SET_MIN : ST_COMMIT;
        end else if (inc_event) begin
          to_d = '0;
          if (state_q == ST_SET_HOUR) begin
            hour_d = bcd_inc_wrap(hour_q, h24 ? HOUR24_MAX : HOUR12_MAX);
          end else begin
            min_d = bcd_inc_wrap(min_q, MIN_MAX);
          end
        end else if (tick_1hz) begin
          if (to_inc == TO_LIMIT) begin
            state_d = ST_RUN;
            to_d    = '0;
            phase_d = 1'b0;
          end else begin
            to_d = to_inc;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_RUN;
        to_d    = '0;
        phase_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    blank_d = 4'b0000;
    if (state_d == ST_SET_HOUR) begin
      blank_d = {phase_d, phase_d, 2'b00};
    end else if (state_d == ST_SET_MIN) begin
      blank_d = {2'b00, phase_d, phase_d};
    end
  end

  // Outputs are registered from next-state so they line up with state_q.
  always_ff @(posedge pCLK) begin
    if (!nRST) begin
      state_q   <= ST_RUN;
      hour_q    <= 8'h00;
      min_q     <= 8'h00;
      to_q      <= '0;
      phase_q   <= 1'b0;
      hold_q    <= 1'b0;
      load_en_q <= 1'b0;
      sec_clr_q <= 1'b0;
      blank_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      to_q      <= to_d;
      phase_q   <= phase_d;
      hold_q    <= (state_d != ST_RUN);
      load_en_q <= (state_d == ST_COMMIT);
      sec_clr_q <= (state_d == ST_COMMIT);
      blank_q   <= blank_d;
    end
  end

  assign hold       = hold_q;
  assign load_en    = load_en_q;
  assign sec_clr    = sec_clr_q;
  assign blank_mask = blank_q;
  assign load_hour  = hour_q;
  assign load_min   = min_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: an event-level model predicts the
// ordered sequence of distinct output vectors; a monitor compares each change.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int TO  = 3;

  logic       pCLK = 1'b0;
  logic       nRST = 1'b0;
  logic       sw_mode_n = 1'b1;
  logic       sw_inc_n = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       h24 = 1'b1;
  logic [7:0] cur_hour = 8'h12;
  logic [7:0] cur_min = 8'h34;
  logic       hold, load_en, sec_clr;
  logic [7:0] load_hour, load_min;
  logic [3:0] blank_mask;
  logic [1:0] state_o;

  always #5 pCLK = ~pCLK;

  time_set_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_TICKS(TO), .TO_W(6)) dut (
    .pCLK       (pCLK),
    .nRST       (nRST),
    .sw_mode_n  (sw_mode_n),
    .sw_inc_n   (sw_inc_n),
    .tick_1hz   (tick_1hz),
    .h24        (h24),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .hold       (hold),
    .load_en    (load_en),
    .load_hour  (load_hour),
    .load_min   (load_min),
    .sec_clr    (sec_clr),
    .blank_mask (blank_mask),
    .state_o    (state_o)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // {state, hold, blank_mask, load_hour, load_min, load_en, sec_clr}
  logic [24:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int          m_state = 0;
  int          m_h = 0;
  int          m_m = 0;
  int          m_phase = 0;
  int          m_to = 0;
  logic [24:0] m_last = '0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [24:0] model_vec();
    logic [3:0] bl;
    bl = 4'b0000;
    if (m_state == 1 && m_phase == 1) bl = 4'b1100;
    if (m_state == 2 && m_phase == 1) bl = 4'b0011;
    return {2'(m_state), (m_state != 0), bl, to_bcd(m_h), to_bcd(m_m),
            (m_state == 3), (m_state == 3)};
  endfunction

  task automatic model_push();
    logic [24:0] v;
    v = model_vec();
    if (v !== m_last) begin
      exp_q.push_back(v);
      m_last = v;
    end
  endtask

  task automatic model_mode();
    case (m_state)
      0: begin
        m_h = from_bcd(cur_hour);
        m_m = from_bcd(cur_min);
        m_state = 1;
        m_to = 0;
        model_push();
      end
      1: begin
        m_state = 2;
        m_to = 0;
        model_push();
      end
      2: begin
        m_state = 3;
        model_push();
        m_state = 0;
        m_phase = 0;
        m_to = 0;
        model_push();
      end
      default: ;
    endcase
  endtask

  task automatic model_inc();
    int lim;
    if (m_state == 1) begin
      lim = h24 ? 23 : 11;
      m_h = (m_h >= lim) ? 0 : m_h + 1;
      m_to = 0;
      model_push();
    end else if (m_state == 2) begin
      m_m = (m_m >= 59) ? 0 : m_m + 1;
      m_to = 0;
      model_push();
    end
  endtask

  task automatic model_tick();
    if (m_state == 1 || m_state == 2) begin
      m_phase = 1 - m_phase;
      m_to++;
      if (m_to == TO) begin
        m_state = 0;
        m_phase = 0;
        m_to = 0;
      end
      model_push();
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge pCLK);
    #1;
  endtask

  task automatic set_sw(input bit dm, input bit di, input logic v);
    if (dm) sw_mode_n = v;
    if (di) sw_inc_n = v;
  endtask

  task automatic press(input bit dm, input bit di, input bit fixed);
    int nb;
    if (fixed) begin
      set_sw(dm, di, 1'b0); cyc(1);
      set_sw(dm, di, 1'b1); cyc(1);
    end else begin
      nb = $urandom_range(0, 2);
      for (int i = 0; i < nb; i++) begin
        set_sw(dm, di, 1'b0); cyc($urandom_range(1, DEB - 1));
        set_sw(dm, di, 1'b1); cyc($urandom_range(1, DEB - 1));
      end
    end
    set_sw(dm, di, 1'b0); cyc(DEB + 6);
    nb = $urandom_range(0, 2);
    for (int i = 0; i < nb; i++) begin
      set_sw(dm, di, 1'b1); cyc($urandom_range(1, DEB - 1));
      set_sw(dm, di, 1'b0); cyc($urandom_range(1, DEB - 1));
    end
    set_sw(dm, di, 1'b1); cyc(DEB + 6);
  endtask

  task automatic op_mode(input bit fixed);
    model_mode();
    press(1'b1, 1'b0, fixed);
  endtask

  task automatic op_inc();
    model_inc();
    press(1'b0, 1'b1, 1'b0);
  endtask

  task automatic op_both();
    model_mode();
    press(1'b1, 1'b1, 1'b0);
  endtask

  task automatic op_tick();
    model_tick();
    tick_1hz = 1'b1; cyc(1);
    tick_1hz = 1'b0; cyc(2);
  endtask

  // ---------------- monitor ----------------
  logic        mon_en = 1'b0;
  logic [24:0] mon_last = '0;
  logic [24:0] mon_v;
  logic [24:0] mon_e;

  always @(negedge pCLK) begin
    if (mon_en) begin
      mon_v = {state_o, hold, blank_mask, load_hour, load_min, load_en, sec_clr};
      if (mon_v !== mon_last) begin
        mon_last = mon_v;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL out_unexpected: got %0h expected no change", mon_v);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_seq", 32'(mon_v), 32'(mon_e));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    sw_mode_n = 1'b0;
    repeat (3) @(posedge pCLK);
    @(negedge pCLK);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_load_en", 32'(load_en), 32'd0);
    check("rst_blank", 32'(blank_mask), 32'd0);
    check("rst_sec_clr", 32'(sec_clr), 32'd0);
    check("rst_shadow", 32'({load_hour, load_min}), 32'h0000);
    mon_last = '0;
    m_last = '0;
    mon_en = 1'b1;

    // Mode held low through reset: the press appears only after debounce.
    model_mode();
    @(posedge pCLK); #1;
    nRST = 1'b1;
    cyc(DEB);
    check("deb_wait", 32'(state_o), 32'd0);
    cyc(DEB + 6);
    sw_mode_n = 1'b1;
    cyc(DEB + 6);

    repeat (TO) op_tick();

    // Fixed bounce 0,1,0,0,0,0 -> single press, then simultaneous mode+inc.
    op_mode(1'b1);
    op_both();
    op_mode(1'b0);

    h24 = 1'b1; cur_hour = 8'h23; cur_min = 8'h58;
    op_mode(1'b0); op_inc(); op_mode(1'b0); op_inc(); op_inc(); op_mode(1'b0);

    h24 = 1'b0; cur_hour = 8'h09; cur_min = 8'h19;
    op_mode(1'b0); op_inc(); op_inc(); op_inc();
    op_mode(1'b0); op_inc();
    repeat (TO) op_tick();

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op_mode(1'b0);
        3, 4, 5: op_inc();
        6, 7:    op_tick();
        8:       op_both();
        default: begin
          h24 = ~h24;
          cur_hour = to_bcd($urandom_range(0, 23));
          cur_min = to_bcd($urandom_range(0, 59));
          cyc(1);
        end
      endcase
    end

    cyc(20);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
